aes_enc_iter_ctrl: RTL and testbench

//  Iterative AES-128 encryption sequencer. Owns one 128-bit state register and one round-key register.

---
 rtl/aes_enc_iter_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_aes_enc_iter_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_iter_ctrl.sv
// Iterative AES-128 encryptor: one state and one round-key register, key expanded on the fly.
// Define AES_ABORT_EN to add an abort input that cancels a block while in RUN.
module aes_enc_iter_ctrl #(
    parameter int unsigned NR     = 10,
    parameter int unsigned UNROLL = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
`ifdef AES_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy
);

    if (NR != 10 || !(UNROLL == 1 || UNROLL == 2) || (NR % UNROLL) != 0) begin : g_bad_param
        $error("aes_enc_iter_ctrl: NR must be 10 and UNROLL must be 1 or 2");
    end

    localparam logic [3:0] NR4 = 4'(NR);
    localparam logic [3:0] UN4 = 4'(UNROLL);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] rkey_q, rkey_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [7:0]   rcon_q, rcon_d;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as x^254 (GF(2^8) inverse, 0 -> 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x3, x7, x15, x31, x63, x127, inv;
        x3   = gf_mul(gf_mul(a, a), a);
        x7   = gf_mul(gf_mul(x3, x3), a);
        x15  = gf_mul(gf_mul(x7, x7), a);
        x31  = gf_mul(gf_mul(x15, x15), a);
        x63  = gf_mul(gf_mul(x31, x31), a);
        x127 = gf_mul(gf_mul(x63, x63), a);
        inv  = gf_mul(x127, x127);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {k[23:0], k[31:24]};
        t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        w0 = k[127:96] ^ t ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte (r,c) lives at bits [127-8*(4c+r) -: 8]; SubBytes and ShiftRows are fused.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] t, m;
        logic [7:0]   a0, a1, a2, a3;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                t[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            end
        end
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = t[127 - 32*c -: 8];
            a1 = t[119 - 32*c -: 8];
            a2 = t[111 - 32*c -: 8];
            a3 = t[103 - 32*c -: 8];
            m[127 - 32*c -: 32] = last ? {a0, a1, a2, a3} :
                {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return m ^ rk;
    endfunction

    logic [127:0] key1, key2, blk1, blk2, key_nx, blk_nx;
    logic [7:0]   rcon2, rcon_nx;

    // Second round stage is only selected when UNROLL=2.
    always_comb begin
        key1  = key_expand(rkey_q, rcon_q);
        blk1  = aes_round(blk_q, key1, rnd_q == NR4);
        rcon2 = xtime(rcon_q);
        key2  = key_expand(key1, rcon2);
        blk2  = aes_round(blk1, key2, rnd_q + 4'd1 == NR4);
        if (UNROLL == 2) begin
            key_nx  = key2;
            blk_nx  = blk2;
            rcon_nx = xtime(rcon2);
        end else begin
            key_nx  = key1;
            blk_nx  = blk1;
            rcon_nx = rcon2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) fsm_q <= IDLE;
        else          fsm_q <= fsm_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_q  <= '0;
            rkey_q <= '0;
            rnd_q  <= '0;
            rcon_q <= 8'h01;
        end else begin
            blk_q  <= blk_d;
            rkey_q <= rkey_d;
            rnd_q  <= rnd_d;
            rcon_q <= rcon_d;
        end
    end

    always_comb begin
        fsm_d  = fsm_q;
        blk_d  = blk_q;
        rkey_d = rkey_q;
        rnd_d  = rnd_q;
        rcon_d = rcon_q;
        if (in_valid && (fsm_q == IDLE || (fsm_q == DONE && out_ready))) begin
            fsm_d  = RUN;
            blk_d  = in_block ^ in_key;
            rkey_d = in_key;
            rnd_d  = 4'd1;
            rcon_d = 8'h01;
        end else begin
            case (fsm_q)
                RUN: begin
                    blk_d  = blk_nx;
                    rkey_d = key_nx;
                    rcon_d = rcon_nx;
                    if (rnd_q + UN4 > NR4) fsm_d = DONE;
                    else                   rnd_d = rnd_q + UN4;
`ifdef AES_ABORT_EN
                    if (abort) begin
                        fsm_d  = IDLE;
                        blk_d  = '0;
                        rkey_d = '0;
                        rnd_d  = '0;
                        rcon_d = 8'h01;
                    end
`endif
                end
                DONE:    if (out_ready) fsm_d = IDLE;
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (fsm_q == IDLE) || (fsm_q == DONE && out_ready);
        out_valid = (fsm_q == DONE);
        busy      = (fsm_q == RUN);
    end

    assign out_block = blk_q;

endmodule

// File: tb/tb_aes_enc_iter_ctrl.sv
// Self-checking bench for aes_enc_iter_ctrl: known-answer vectors, latency, backpressure,
// mid-run reset, in_valid held during RUN, and abort when AES_ABORT_EN is defined.
module tb_aes_enc_iter_ctrl;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid, in_valid2, out_ready, out_ready2;
    logic [127:0] in_block, in_key;
    logic         in_ready, in_ready2, out_valid, out_valid2, busy, busy2;
    logic [127:0] out_block, out_block2;
`ifdef AES_ABORT_EN
    logic         abort, abort2;
`endif

    always #5 clk = ~clk;

    aes_enc_iter_ctrl #(.NR(10), .UNROLL(1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_block(in_block), .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready),
        .out_block(out_block),
`ifdef AES_ABORT_EN
        .abort(abort),
`endif
        .busy(busy)
    );

    aes_enc_iter_ctrl #(.NR(10), .UNROLL(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_block(in_block), .in_key(in_key), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_block(out_block2),
`ifdef AES_ABORT_EN
        .abort(abort2),
`endif
        .busy(busy2)
    );

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs[5];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_blk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input bit sel, input logic [127:0] key, input logic [127:0] pt);
        int guard;
        guard = 0;
        @(negedge clk);
        in_block = pt;
        in_key   = key;
        if (sel) in_valid2 = 1'b1;
        else     in_valid  = 1'b1;
        while (!(sel ? in_ready2 : in_ready) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_bit("in_ready_at_accept", sel ? in_ready2 : in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the accept edge; lat stays 0 on timeout.
    task automatic wait_out(input bit sel, output int lat, output logic [127:0] ct);
        lat = 0;
        ct  = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (sel ? out_valid2 : out_valid) begin
                lat = i;
                ct  = sel ? out_block2 : out_block;
                break;
            end
        end
    endtask

    task automatic pop(input bit sel);
        @(negedge clk);
        if (sel) out_ready2 = 1'b1;
        else     out_ready  = 1'b1;
        @(posedge clk);
        #1;
        out_ready  = 1'b0;
        out_ready2 = 1'b0;
        check_bit("out_valid_after_pop", sel ? out_valid2 : out_valid, 1'b0);
    endtask

    task automatic run_vec(input bit sel, input vec_t v, input int exp_lat);
        int           lat;
        logic [127:0] ct;
        send(sel, v.key, v.pt);
        wait_out(sel, lat, ct);
        check_blk(sel ? "ct_unroll2" : "ct_unroll1", ct, v.ct);
        check_int(sel ? "latency_unroll2" : "latency_unroll1", lat, exp_lat);
        pop(sel);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        int           seen;
        logic [127:0] ct;

        vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    pt:  128'h3243f6a8885a308d313198a2e0370734,
                    ct:  128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                    pt:  128'h00112233445566778899aabbccddeeff,
                    ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{key: 128'h0,
                    pt:  128'h0,
                    ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        vecs[3] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    pt:  128'h6bc1bee22e409f96e93d7e117393172a,
                    ct:  128'h3ad77bb40d7a3660a89ecaf32466ef97};
        vecs[4] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    pt:  128'hae2d8a571e03ac9c9eb76fac45af8e51,
                    ct:  128'hf5d3d58503b9699de785895a96fdbaaf};

        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_valid2  = 1'b0;
        out_ready  = 1'b0;
        out_ready2 = 1'b0;
        in_block   = '0;
        in_key     = '0;
`ifdef AES_ABORT_EN
        abort      = 1'b0;
        abort2     = 1'b0;
`endif

        repeat (2) @(negedge clk);
        check_bit("rst_in_ready", in_ready, 1'b1);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_blk("rst_out_block", out_block, '0);
        check_bit("rst_in_ready_u2", in_ready2, 1'b1);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_vec(1'b0, vecs[i], 11);
            run_vec(1'b1, vecs[i], 6);
        end

        // Backpressure: result held for 20 cycles, then back-to-back accept of the next block.
        send(1'b0, vecs[0].key, vecs[0].pt);
        check_bit("busy_in_run", busy, 1'b1);
        check_bit("in_ready_in_run", in_ready, 1'b0);
        wait_out(1'b0, lat, ct);
        check_blk("bp_first_ct", ct, vecs[0].ct);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_bit("bp_out_valid_hold", out_valid, 1'b1);
            check_blk("bp_out_block_hold", out_block, vecs[0].ct);
            check_bit("bp_in_ready_low", in_ready, 1'b0);
        end
        @(negedge clk);
        in_valid  = 1'b1;
        in_block  = vecs[1].pt;
        in_key    = vecs[1].key;
        out_ready = 1'b1;
        #1;
        check_bit("b2b_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_bit("b2b_busy", busy, 1'b1);
        check_bit("b2b_out_valid_drop", out_valid, 1'b0);
        wait_out(1'b0, lat, ct);
        check_blk("b2b_second_ct", ct, vecs[1].ct);
        check_int("b2b_latency", lat, 11);
        pop(1'b0);

        // Asynchronous reset in the middle of a block.
        send(1'b0, vecs[1].key, vecs[1].pt);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_bit("midrst_out_valid", out_valid, 1'b0);
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_in_ready", in_ready, 1'b1);
        check_blk("midrst_out_block", out_block, '0);
        @(negedge clk);
        reset_n = 1'b1;
        run_vec(1'b0, vecs[0], 11);

        // in_valid held with changing data during RUN must be ignored.
        @(negedge clk);
        in_valid = 1'b1;
        in_block = vecs[0].pt;
        in_key   = vecs[0].key;
        @(posedge clk);
        #1;
        lat = 0;
        ct  = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                ct  = out_block;
                break;
            end
            in_block = {$urandom, $urandom, $urandom, $urandom};
            in_key   = {$urandom, $urandom, $urandom, $urandom};
        end
        in_valid = 1'b0;
        check_blk("hold_valid_ct", ct, vecs[0].ct);
        check_int("hold_valid_latency", lat, 11);
        pop(1'b0);

`ifdef AES_ABORT_EN
        send(1'b0, vecs[1].key, vecs[1].pt);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_in_ready", in_ready, 1'b1);
        check_blk("abort_out_block", out_block, '0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_int("abort_no_out_valid", seen, 0);
        run_vec(1'b0, vecs[0], 11);
`else
        seen = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
